// File: rtl/fpga_gpio_irq_registers.sv
// fpga_gpio_irq_registers: Wishbone ID/GPIO/scratch register block with optional per-pin edge interrupts.
// Define FPGA_GPIO_IRQ_EN to build the edge-detect, IRQ enable/status registers and Interrupt_o.
module fpga_gpio_irq_registers #(
    parameter int          ADDRWIDTH     = 7,
    parameter int          DATAWIDTH     = 32,
    parameter int          GPIO_WIDTH    = 16,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [23:0] DEVICE_ID     = 24'h55C332,
    parameter logic [31:0] SCRATCH_RST   = 32'h12345678,
    parameter logic [31:0] DEF_REG_VALUE = 32'hFABDEFAC
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
    input  logic                  WBs_CYC_i,
    input  logic                  WBs_STB_i,
    input  logic                  WBs_WE_i,
    input  logic [3:0]            WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]  WBs_DAT_i,
    output logic [DATAWIDTH-1:0]  WBs_DAT_o,
    output logic                  WBs_ACK_o,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN_i,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT_o,
    output logic [GPIO_WIDTH-1:0] GPIO_OE_o,
    output logic                  Interrupt_o
);
    logic                  ack;
    logic                  wr;
    logic [31:0]           lane_mask;
    logic [GPIO_WIDTH-1:0] pin_mask;
    logic [GPIO_WIDTH-1:0] pin_dat;
    logic [GPIO_WIDTH-1:0] gpio_out;
    logic [GPIO_WIDTH-1:0] gpio_oe;
    logic [GPIO_WIDTH-1:0] gpio_in;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATAWIDTH-1:0]  scratch;
    logic [DATAWIDTH-1:0]  rd;

    assign wr        = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~ack;
    assign lane_mask = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                        {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
    assign pin_mask  = lane_mask[GPIO_WIDTH-1:0];
    assign pin_dat   = WBs_DAT_i[GPIO_WIDTH-1:0];
    assign gpio_in   = sync_q[SYNC_STAGES-1];

    function automatic logic hit(input int a);
        return wr && (WBs_ADR_i == ADDRWIDTH'(a));
    endfunction

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            ack <= 1'b0;
        else
            ack <= WBs_CYC_i & WBs_STB_i & ~ack;
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
            scratch  <= SCRATCH_RST;
        end else begin
            if (hit(2))
                gpio_out <= (gpio_out & ~pin_mask) | (pin_dat & pin_mask);
            if (hit(3))
                gpio_oe <= (gpio_oe & ~pin_mask) | (pin_dat & pin_mask);
            if (hit(7))
                scratch <= (scratch & ~lane_mask) | (WBs_DAT_i & lane_mask);
        end
    end

    // pins are asynchronous; nothing downstream looks at them before the last stage
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
        end else begin
            sync_q[0] <= GPIO_IN_i;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef FPGA_GPIO_IRQ_EN
    localparam int CW = $clog2(SYNC_STAGES + 2);

    logic [GPIO_WIDTH-1:0] rise_en;
    logic [GPIO_WIDTH-1:0] fall_en;
    logic [GPIO_WIDTH-1:0] status;
    logic [GPIO_WIDTH-1:0] prev;
    logic [GPIO_WIDTH-1:0] set;
    logic [GPIO_WIDTH-1:0] clr;
    logic [CW-1:0]         arm_cnt;
    logic                  armed;
    logic                  irq;

    // hold off until the synchroniser and history flop hold real post-reset samples
    assign armed = arm_cnt == CW'(SYNC_STAGES + 1);
    assign set   = armed ? ((gpio_in & ~prev & rise_en) | (~gpio_in & prev & fall_en)) : '0;
    assign clr   = hit(6) ? (pin_dat & pin_mask) : '0;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            arm_cnt <= '0;
            prev    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            irq     <= 1'b0;
        end else begin
            arm_cnt <= armed ? arm_cnt : arm_cnt + CW'(1);
            prev    <= gpio_in;
            if (hit(4))
                rise_en <= (rise_en & ~pin_mask) | (pin_dat & pin_mask);
            if (hit(5))
                fall_en <= (fall_en & ~pin_mask) | (pin_dat & pin_mask);
            status <= (status & ~clr) | set;
            irq    <= |status;
        end
    end

    assign Interrupt_o = irq;
`else
    assign Interrupt_o = 1'b0;
`endif

    always_comb begin
        rd = DEF_REG_VALUE;
        case (WBs_ADR_i)
            ADDRWIDTH'(0): rd = {8'h0, DEVICE_ID};
            ADDRWIDTH'(1): rd = DATAWIDTH'(gpio_in);
            ADDRWIDTH'(2): rd = DATAWIDTH'(gpio_out);
            ADDRWIDTH'(3): rd = DATAWIDTH'(gpio_oe);
`ifdef FPGA_GPIO_IRQ_EN
            ADDRWIDTH'(4): rd = DATAWIDTH'(rise_en);
            ADDRWIDTH'(5): rd = DATAWIDTH'(fall_en);
            ADDRWIDTH'(6): rd = DATAWIDTH'(status);
`endif
            ADDRWIDTH'(7): rd = scratch;
            default:       rd = DEF_REG_VALUE;
        endcase
    end

    assign WBs_DAT_o  = rd;
    assign WBs_ACK_o  = ack;
    assign GPIO_OUT_o = gpio_out;
    assign GPIO_OE_o  = gpio_oe;
endmodule

// File: tb/tb_fpga_gpio_irq_registers.sv
// tb_fpga_gpio_irq_registers: directed bench with a cycle model of the register map and pin-edge timing.
module tb_fpga_gpio_irq_registers;
    localparam int          AW  = 7;
    localparam int          W   = 16;
    localparam int          SS  = 2;
    localparam logic [31:0] DEF = 32'hFABDEFAC;
    localparam logic [31:0] PM  = 32'h0000FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] adr = '0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we  = 1'b0;
    logic [3:0]    be  = '0;
    logic [31:0]   dat = '0;
    logic [31:0]   dout;
    logic          ack;
    logic [W-1:0]  pins = '0;
    logic [W-1:0]  gout;
    logic [W-1:0]  goe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    fpga_gpio_irq_registers #(.ADDRWIDTH(AW), .GPIO_WIDTH(W), .SYNC_STAGES(SS)) dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
        .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_DAT_i(dat),
        .WBs_DAT_o(dout), .WBs_ACK_o(ack), .GPIO_IN_i(pins), .GPIO_OUT_o(gout),
        .GPIO_OE_o(goe), .Interrupt_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // model state: registers, ack, and the raw pin sample taken at each clock edge
    logic        m_ack, m_irq, m_wr;
    logic [31:0] m_out, m_oe, m_ren, m_fen, m_st, m_scr, m_set, m_clr, m_rise, m_fall;
    logic [31:0] hist [0:SS+1];
    int          e;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < 4; i++)
            if (b[i]) old[8*i +: 8] = d[8*i +: 8];
        return old;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        case (a)
            0: return 32'h0055C332;
            1: return hist[SS-1];
            2: return m_out;
            3: return m_oe;
`ifdef FPGA_GPIO_IRQ_EN
            4: return m_ren;
            5: return m_fen;
            6: return m_st;
`endif
            7: return m_scr;
            default: return DEF;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack = 0; m_irq = 0; m_out = 0; m_oe = 0; m_ren = 0; m_fen = 0; m_st = 0;
            m_scr = 32'h12345678;
            for (int i = 0; i <= SS + 1; i++) hist[i] = 0;
            e = 0;
        end else begin
            m_wr  = cyc & stb & we & ~m_ack;
            m_ack = cyc & stb & ~m_ack;
            for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = 32'(pins);
            e++;
            // hist[SS] is the synchronised value seen before this edge, hist[SS+1] the one before that
            m_rise = hist[SS] & ~hist[SS+1];
            m_fall = ~hist[SS] & hist[SS+1];
`ifdef FPGA_GPIO_IRQ_EN
            m_set = (e >= SS + 2) ? ((m_rise & m_ren) | (m_fall & m_fen)) : 32'h0;
            m_clr = (m_wr && adr == 6) ? (merge(32'h0, dat, be) & PM) : 32'h0;
            m_irq = |m_st;
            m_st  = (m_st & ~m_clr) | m_set;
`endif
            if (m_wr)
                case (adr)
                    2: m_out = merge(m_out, dat, be) & PM;
                    3: m_oe  = merge(m_oe, dat, be) & PM;
`ifdef FPGA_GPIO_IRQ_EN
                    4: m_ren = merge(m_ren, dat, be) & PM;
                    5: m_fen = merge(m_fen, dat, be) & PM;
`endif
                    7: m_scr = merge(m_scr, dat, be);
                    default: ;
                endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("gpio_out", 32'(gout), m_out);
            chk("gpio_oe", 32'(goe), m_oe);
            chk("irq", 32'(irq), 32'(m_irq));
            if (m_ack) chk("rdata", dout, exp_rd(adr));
        end
    end

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; be = b; r = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                r = dout;
                break;
            end
        end
        if (!ack) chk("ack_timeout", 32'(ack), 32'h1);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        xfer(1'b1, a, d, b, r);
    endtask

    task automatic rd(input string n, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'h0, 4'h0, r);
        chk(n, r, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] irq_def;
`ifdef FPGA_GPIO_IRQ_EN
        irq_def = 32'h0;
`else
        irq_def = DEF;
`endif
        cycles(3);
        rst = 0;
        cycles(1);
        rd("id", 0, 32'h0055C332);
        rd("gpio_in_rst", 1, 32'h0);
        rd("gpio_out_rst", 2, 32'h0);
        rd("gpio_oe_rst", 3, 32'h0);
        rd("rise_en_rst", 4, irq_def);
        rd("fall_en_rst", 5, irq_def);
        rd("status_rst", 6, irq_def);
        rd("scratch_rst", 7, 32'h12345678);
        rd("unmapped", 9, DEF);
        wr(0, 32'hFFFFFFFF, 4'hF);
        rd("id_ro", 0, 32'h0055C332);

        wr(7, 32'hA5A5A5A5, 4'b0101);
        rd("scratch_lanes", 7, 32'h12A556A5);
        wr(3, 32'hFFFFFFFF, 4'hF);
        chk("oe_pins", 32'(goe), 32'h0000FFFF);
        rd("oe_rb", 3, 32'h0000FFFF);
        wr(2, 32'h1234ABCD, 4'b0001);
        rd("out_lane0", 2, 32'h000000CD);
        wr(9, 32'h11111111, 4'hF);
        rd("unmapped_wr", 9, DEF);

        pins = 16'hBEEF;
        cycles(4);
        rd("gpio_in", 1, 32'h0000BEEF);
        pins = 16'h0;
        cycles(4);

`ifdef FPGA_GPIO_IRQ_EN
        wr(4, 32'h8, 4'hF);
        pins[3] = 1'b1;
        cycles(SS + 1);
        chk("irq_pre", 32'(irq), 32'h0);
        cycles(1);
        chk("irq_rise", 32'(irq), 32'h1);
        rd("status_b3", 6, 32'h8);
        pins[3] = 1'b0;
        cycles(6);
        rd("status_nofall", 6, 32'h8);
        wr(6, 32'h8, 4'hF);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd("status_clr", 6, 32'h0);

        wr(4, 32'h9, 4'hF);
        pins[0] = 1'b1;
        cycles(6);
        rd("status_b0", 6, 32'h1);
        pins[0] = 1'b0;
        cycles(4);
        pins[0] = 1'b1;
        cycles(SS);
        wr(6, 32'h1, 4'hF);
        chk("irq_setwins", 32'(irq), 32'h1);
        rd("status_setwins", 6, 32'h1);
        wr(6, 32'hFFFFFFFF, 4'hF);
        cycles(2);

        pins = 16'hFFFF;
        rst = 1;
        cycles(2);
        rst = 0;
        wr(4, 32'hFFFFFFFF, 4'hF);
        cycles(10);
        rd("status_noarm", 6, 32'h0);
        chk("irq_noarm", 32'(irq), 32'h0);
        pins = 16'hFFDF;
        cycles(5);
        rd("status_fall_off", 6, 32'h0);
        pins = 16'hFFFF;
        cycles(5);
        rd("status_b5", 6, 32'h20);
`else
        wr(4, 32'hFFFF, 4'hF);
        rd("rise_en_absent", 4, DEF);
        pins = 16'h00FF;
        cycles(6);
        chk("irq_absent", 32'(irq), 32'h0);
`endif

        wr(7, 32'hCAFEF00D, 4'hF);
        cyc = 1; stb = 1; we = 0; adr = 7;
        cycles(1);
        chk("ack_midxfer", 32'(ack), 32'h1);
        rst = 1;
        #1;
        chk("ack_async_drop", 32'(ack), 32'h0);
        cyc = 0; stb = 0;
        cycles(1);
        rst = 0;
        cycles(1);
        rd("scratch_after_rst", 7, 32'h12345678);
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
